rng_scheduler: RTL and testbench
================================

# rng_scheduler

Shared random-number service for the CPU and peripheral requesters. Owns a 32-bit Fibonacci LFSR and hands out one random word per grant to up to NUM_REQ requesters under round-robin arbitration. A programmable cooldown between grants ensures consecutive draws are separated by several LFSR steps. Sits between the random-source datapath and its consumers (CPU random-read path, game/entity logic).

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- MIN_GAP, 4: LFSR steps between consecutive grants (>=1)
- SEED, 32'hAEAF696C: reset state of the LFSR and fallback for an all-zero seed load
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester request, level; held until granted
- seed_load  in  1  single-cycle pulse, load seed_value
- seed_value  in  32  new LFSR state
- grant  out  NUM_REQ  one-hot grant, single-cycle pulse
- grant_id  out  $clog2(NUM_REQ)  index of granted requester, valid with rand_valid
- rand_valid  out  1  single-cycle pulse coincident with grant
- rand_data  out  32  raw LFSR word
- rand_small  out  32  signed 4-bit value sign-extended to 32 bits

## Operation
- LFSR steps every cycle: next = {s[30:0], s[31]^s[6]^s[5]^s[1]}.
- seed_load: next state = seed_value, or SEED if seed_value==0. Overrides the step. Does not affect the FSM or the gap counter.
- gap counter: cleared in the grant cycle, increments each cycle, saturates at MIN_GAP.
- FSM states:
  - IDLE: if req!=0 and gap==MIN_GAP, arbitrate and go to GRANT; otherwise stay.
  - GRANT: one cycle with outputs asserted, then COOL.
  - COOL: requests ignored; when gap==MIN_GAP, go to IDLE.
- Round robin: search starts at last_winner+1 mod NUM_REQ. last_winner updates on grant.
- rand_data and rand_small capture the LFSR value present in the arbitration cycle (the IDLE cycle that decided).
- rand_small: n = LFSR[3:0], sign-extended. n==4'b1000 maps to 0, giving a symmetric range of -7..+7.
- Withdrawal: a req dropped before arbitration is simply not considered. A req dropped in the arbitration cycle is already sampled and is still granted.
- Reset values:
  - LFSR = SEED, state IDLE, gap = MIN_GAP.
  - last_winner = NUM_REQ-1, so requester 0 has first priority.
  - grant, grant_id, rand_valid, rand_data and rand_small = 0.

## Timing
- Request seen in IDLE at cycle t with gap saturated: grant/rand_valid high at t+1, for exactly one cycle.
- Minimum grant spacing: MIN_GAP+1 cycles (grant at G, next arbitration at G+MIN_GAP, next grant at G+MIN_GAP+1).
- Outputs are registered; no combinational path from req to grant.
- Seed load at cycle t: LFSR = new value at t+1. A seed load in the arbitration cycle does not change the sampled word.
- Reset mid-COOL or mid-GRANT: immediate return to reset values. The pending grant pulse is dropped.

## Structure
- Shared package: LFSR tap constant and polynomial step function, the FSM state enum, and the rand_small mapping function (the -8 to 0 mapping is reused by CPU random-instruction decode).
- One sub-module, rng_lfsr32: state register, step, and seed load with zero-guard. Ports: clock, reset, load, load_value, state.
- Arbiter, gap counter and FSM stay in rng_scheduler.

## Test plan
- Reset, then req=4'b1111 held: grant_id sequence 0,1,2,3,0, with grants 5 cycles apart (MIN_GAP=4). First grant one cycle after req is first sampled.
- seed_load=1, seed_value=32'h1 at t; req[0] rises at t+1:
  - t+2: grant=4'b0001, rand_data=32'h1, rand_small=32'h1.
  - req[0] held: next grant at t+7 with rand_data=32'h2A, rand_small=32'hFFFFFFFA.
- seed_value=32'h0 load: LFSR equals 32'hAEAF696C on the next cycle. A subsequent grant returns the reference-model value, never 0.
- seed_value=32'h8, then req[2] in the following cycle: rand_data=32'h8, rand_small=32'h0 (the -8 mapping).
- req[1] pulsed only during COOL, then dropped: no grant ever issues for requester 1. Other requesters are unaffected.
- Reset asserted during COOL after a grant to requester 2:
  - All outputs go to 0 immediately.
  - After release, req=4'b0110 grants requester 1 first (pointer reset), with rand_data from the SEED sequence.

Source files
------------

// File: rtl/rng_scheduler_pkg.sv
// Shared definitions for the random-number scheduler: LFSR polynomial, FSM states
// and the small signed random mapping reused by the CPU random-instruction decode.
package rng_scheduler_pkg;

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned SMALL_W = 4;

    // Feedback taps at bits 31, 6, 5 and 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8000_0062;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // -8 folds to 0 so the range is symmetric (-7..+7)
    function automatic logic [LFSR_W-1:0] rand_small_map(input logic [SMALL_W-1:0] n);
        logic [LFSR_W-1:0] r;
        if (n == 4'b1000) begin
            r = '0;
        end else begin
            r = {{(LFSR_W - SMALL_W){n[SMALL_W-1]}}, n};
        end
        return r;
    endfunction

endpackage

// File: rtl/rng_lfsr32.sv
// 32-bit Fibonacci LFSR stepping every cycle, with a zero-guarded seed load.
module rng_lfsr32
    import rng_scheduler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'hAEAF696C
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] state
);

    // An all-zero state would lock the LFSR, so a zero load falls back to SEED
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_value == '0) ? SEED : load_value;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/rng_scheduler.sv
// Round-robin random-word service: one LFSR word per grant, with a cooldown
// between grants so consecutive draws are several LFSR steps apart.
module rng_scheduler
    import rng_scheduler_pkg::*;
#(
    parameter int unsigned       NUM_REQ = 4,
    parameter int unsigned       MIN_GAP = 4,
    parameter logic [LFSR_W-1:0] SEED    = 32'hAEAF696C
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       seed_load,
    input  logic [LFSR_W-1:0]          seed_value,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       rand_valid,
    output logic [LFSR_W-1:0]          rand_data,
    output logic [LFSR_W-1:0]          rand_small
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_EXIT = GAP_W'(MIN_GAP - 1);

    state_t            state_q;
    state_t            state_d;
    logic              arb_fire;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_d;
    logic [ID_W-1:0]   last_winner;
    logic [ID_W-1:0]   scan_idx;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic [LFSR_W-1:0] lfsr_state;

    rng_lfsr32 #(
        .SEED(SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (seed_load),
        .load_value (seed_value),
        .state      (lfsr_state)
    );

    // Round robin: scan downward so the entry just after last_winner is written last and wins
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            scan_idx = ID_W'((32'(last_winner) + k) % NUM_REQ);
            if (req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // COOL leaves one cycle early so IDLE is entered exactly as the gap saturates
    always_comb begin
        state_d  = state_q;
        arb_fire = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid && (gap_q == GAP_MAX)) begin
                    arb_fire = 1'b1;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: state_d = ST_COOL;
            ST_COOL: begin
                if (gap_q >= GAP_EXIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gap reads zero during the grant cycle, then counts up and saturates
    always_comb begin
        gap_d = gap_q;
        if (arb_fire) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_q       <= GAP_MAX;
            last_winner <= ID_W'(NUM_REQ - 1);
            grant       <= '0;
            grant_id    <= '0;
            rand_valid  <= 1'b0;
            rand_data   <= '0;
            rand_small  <= '0;
        end else begin
            gap_q      <= gap_d;
            grant      <= '0;
            rand_valid <= arb_fire;
            if (arb_fire) begin
                last_winner <= pick_id;
                grant       <= NUM_REQ'(1) << pick_id;
                grant_id    <= pick_id;
                rand_data   <= lfsr_state;
                rand_small  <= rand_small_map(lfsr_state[SMALL_W-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed bench for rng_scheduler: round robin, cooldown spacing, seed loads,
// the -8 mapping, withdrawal during cooldown and reset mid-cooldown.
module tb_rng_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned MIN_GAP = 4;
    localparam logic [31:0] SEED    = 32'hAEAF696C;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic [3:0]  req        = '0;
    logic        seed_load  = 1'b0;
    logic [31:0] seed_value = '0;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        rand_valid;
    logic [31:0] rand_data;
    logic [31:0] rand_small;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_lfsr;
    logic [31:0] ref_prev;

    rng_scheduler #(
        .NUM_REQ (NUM_REQ),
        .MIN_GAP (MIN_GAP),
        .SEED    (SEED)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .grant      (grant),
        .grant_id   (grant_id),
        .rand_valid (rand_valid),
        .rand_data  (rand_data),
        .rand_small (rand_small)
    );

    always #5 clock = ~clock;

    // Reference LFSR; ref_prev holds the word present in the previous cycle
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_lfsr <= SEED;
            ref_prev <= SEED;
        end else begin
            ref_prev <= ref_lfsr;
            if (seed_load) begin
                ref_lfsr <= (seed_value == 32'h0) ? SEED : seed_value;
            end else begin
                ref_lfsr <= {ref_lfsr[30:0], ref_lfsr[31] ^ ref_lfsr[6] ^ ref_lfsr[5] ^ ref_lfsr[1]};
            end
        end
    end

    function automatic logic [31:0] small_ref(input logic [31:0] w);
        logic [3:0] n;
        n = w[3:0];
        if (n == 4'h8) return 32'h0;
        return {{28{n[3]}}, n};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int id, input logic [31:0] exp_data,
                                input logic [31:0] exp_small);
        check({tag, ".grant"},      32'(grant),      32'(4'b0001 << id));
        check({tag, ".grant_id"},   32'(grant_id),   32'(id));
        check({tag, ".rand_valid"}, 32'(rand_valid), 32'h1);
        check({tag, ".rand_data"},  rand_data,       exp_data);
        check({tag, ".rand_small"}, rand_small,      exp_small);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, ".grant"},      32'(grant),      32'h0);
            check({tag, ".rand_valid"}, 32'(rand_valid), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] w;

        // Reset values
        #1 reset = 1'b1;
        #5;
        check("rst.grant",      32'(grant),      32'h0);
        check("rst.grant_id",   32'(grant_id),   32'h0);
        check("rst.rand_valid", 32'(rand_valid), 32'h0);
        check("rst.rand_data",  rand_data,       32'h0);
        check("rst.rand_small", rand_small,      32'h0);

        // All four requesting: 0,1,2,3,0, five cycles apart
        @(posedge clock);
        #1;
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        expect_grant("rr0", 0, SEED, 32'hFFFF_FFFC);
        for (int k = 1; k <= 4; k++) begin
            expect_quiet("rr.gap", 4);
            tick();
            w = ref_prev;
            expect_grant("rr", k % 4, w, small_ref(w));
        end
        req = 4'b0000;
        expect_quiet("rr.idle", 6);

        // Seed 1, then req[0]: words 1 and 0x2A five steps later
        seed_load  = 1'b1;
        seed_value = 32'h1;
        tick();
        seed_load = 1'b0;
        req       = 4'b0001;
        tick();
        expect_grant("seed1.a", 0, 32'h1, 32'h1);
        expect_quiet("seed1.gap", 4);
        tick();
        expect_grant("seed1.b", 0, 32'h2A, 32'hFFFF_FFFA);
        req = 4'b0000;
        expect_quiet("seed1.idle", 6);

        // Zero seed falls back to SEED
        seed_load  = 1'b1;
        seed_value = 32'h0;
        tick();
        seed_load = 1'b0;
        req       = 4'b1000;
        tick();
        expect_grant("seed0", 3, SEED, 32'hFFFF_FFFC);
        req = 4'b0000;
        expect_quiet("seed0.idle", 6);

        // Nibble 4'b1000 maps to zero
        seed_load  = 1'b1;
        seed_value = 32'h8;
        tick();
        seed_load = 1'b0;
        req       = 4'b0100;
        tick();
        expect_grant("seed8", 2, 32'h8, 32'h0);

        // req[1] pulsed only during cooldown is never granted
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        expect_quiet("withdraw", 8);

        // Seed load in the arbitration cycle does not alter the captured word
        req        = 4'b0001;
        seed_load  = 1'b1;
        seed_value = 32'h0000_1234;
        tick();
        seed_load = 1'b0;
        req       = 4'b0000;
        w         = ref_prev;
        expect_grant("arbload", 0, w, small_ref(w));
        expect_quiet("arbload.idle", 5);

        // Grant to 2, then reset in COOL
        req = 4'b0100;
        tick();
        w = ref_prev;
        expect_grant("pre_rst", 2, w, small_ref(w));
        req = 4'b0000;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrst.grant",      32'(grant),      32'h0);
        check("midrst.grant_id",   32'(grant_id),   32'h0);
        check("midrst.rand_valid", 32'(rand_valid), 32'h0);
        check("midrst.rand_data",  rand_data,       32'h0);
        check("midrst.rand_small", rand_small,      32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req   = 4'b0110;
        tick();
        expect_grant("post_rst", 1, SEED, 32'hFFFF_FFFC);
        req = 4'b0000;
        expect_quiet("post_rst.idle", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
